// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache: state encoding,
// NOP constant, default geometry and the derived address-field widths.
package icache_ctrl_pkg;

    localparam int unsigned DEF_LINES  = 32;
    localparam int unsigned DEF_WORDS  = 4;
    localparam int unsigned DEF_ADDR_W = 16;

    // Address split for the default geometry: {tag, index, offset, byte}
    localparam int unsigned OFF_W = $clog2(DEF_WORDS);
    localparam int unsigned IDX_W = $clog2(DEF_LINES);
    localparam int unsigned TAG_W = DEF_ADDR_W - IDX_W - OFF_W - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    // Saturating 16-bit increment used by the optional statistics counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Flop-based storage for the instruction cache: data, tag and valid arrays.
// Combinational read port, synchronous word write, synchronous tag/valid write
// and a synchronous clear-all of the valid bits (clear wins over a valid set).
module icache_array #(
    parameter int unsigned LINES = 32,
    parameter int unsigned WORDS = 4,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned IDX_W = $clog2(LINES),
    parameter int unsigned OFF_W = $clog2(WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // read port
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [OFF_W-1:0] rd_off_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [15:0]      rd_data_o,
    // word write port
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [OFF_W-1:0] wr_off_i,
    input  logic [15:0]      wr_data_i,
    // tag/valid write port
    input  logic             tv_we_i,
    input  logic [IDX_W-1:0] tv_idx_i,
    input  logic [TAG_W-1:0] tv_tag_i,
    // clear all valid bits
    input  logic             clr_i
);

    logic [15:0]      data_q [LINES][WORDS];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;

    // Data words are written one at a time as the fill returns them
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
    end

    // Tag is only meaningful when the matching valid bit is set, so no reset
    always_ff @(posedge clk_i) begin
        if (tv_we_i) begin
            tag_q[tv_idx_i] <= tv_tag_i;
        end
    end

    // Valid bits: clear-all has priority so a deferred invalidate kills the new line too
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            valid_q <= '0;
        end else if (tv_we_i) begin
            valid_q[tv_idx_i] <= 1'b1;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller in front of fetch.
// Hits return in the same cycle; misses stall fetch while the line is filled
// word by word from a backing memory with one read outstanding.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int unsigned LINES  = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_req,
    input  logic              inval,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic              stall,
    output logic              err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int unsigned OFF_BITS = $clog2(WORDS);
    localparam int unsigned IDX_BITS = $clog2(LINES);
    localparam int unsigned TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS - 1;
    localparam logic [OFF_BITS-1:0] CNT_LAST = OFF_BITS'(WORDS - 1);

    logic [1:0]          state_q, state_d;
    logic [OFF_BITS-1:0] cnt_q, cnt_d;
    logic [TAG_BITS-1:0] line_tag_q, line_tag_d;
    logic [IDX_BITS-1:0] line_idx_q, line_idx_d;
    logic                inval_pend_q, inval_pend_d;

    logic [OFF_BITS-1:0] req_off;
    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;

    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [15:0]         rd_data;

    logic                wr_en;
    logic                tv_we;
    logic                clr_all;

    logic                is_idle;
    logic                aligned_req;
    logic                lookup_hit;
    logic                hit;
    logic                miss;

    assign req_off = fetch_addr[OFF_BITS:1];
    assign req_idx = fetch_addr[OFF_BITS+IDX_BITS:OFF_BITS+1];
    assign req_tag = fetch_addr[ADDR_W-1:OFF_BITS+IDX_BITS+1];

    icache_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TAG_BITS),
        .IDX_W (IDX_BITS),
        .OFF_W (OFF_BITS)
    ) u_array (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_idx_i   (req_idx),
        .rd_off_i   (req_off),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (line_idx_q),
        .wr_off_i   (cnt_q),
        .wr_data_i  (mem_rdata),
        .tv_we_i    (tv_we),
        .tv_idx_i   (line_idx_q),
        .tv_tag_i   (line_tag_q),
        .clr_i      (clr_all)
    );

    // Lookup: only an aligned request in IDLE can hit or start a fill
    always_comb begin
        is_idle     = (state_q == ST_IDLE);
        aligned_req = fetch_req & ~fetch_addr[0];
        lookup_hit  = rd_valid & (rd_tag == req_tag);
        hit         = aligned_req & is_idle & lookup_hit;
        miss        = aligned_req & is_idle & ~lookup_hit;
    end

    // Fetch-side and memory-side outputs
    always_comb begin
        instr_valid = hit;
        instr       = hit ? rd_data : NOP_INSTR;
        stall       = ~is_idle | miss;
        err         = fetch_req & fetch_addr[0];
        mem_req     = (state_q == ST_REQ);
        mem_addr    = {line_tag_q, line_idx_q, cnt_q, 1'b0};
    end

    // Fill FSM; an invalidate seen mid-fill is held until the fill completes
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_tag_d   = line_tag_q;
        line_idx_d   = line_idx_q;
        inval_pend_d = inval_pend_q;
        wr_en        = 1'b0;
        tv_we        = 1'b0;
        clr_all      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Lookup this cycle already used the old valid bits
                clr_all = inval;
                if (miss) begin
                    line_tag_d = req_tag;
                    line_idx_d = req_idx;
                    cnt_d      = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (inval) begin
                    inval_pend_d = 1'b1;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (inval) begin
                    inval_pend_d = 1'b1;
                end
                if (mem_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        tv_we        = 1'b1;
                        clr_all      = inval_pend_q | inval;
                        inval_pend_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state; reset aborts any fill in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            line_tag_q   <= '0;
            line_idx_q   <= '0;
            inval_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_tag_q   <= line_tag_d;
            line_idx_q   <= line_idx_d;
            inval_pend_q <= inval_pend_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Hits count per hit cycle; misses count once per fill started
    always_comb begin
        hit_cnt_d  = hit ? sat_inc16(hit_cnt_q) : hit_cnt_q;
        miss_cnt_d = miss ? sat_inc16(miss_cnt_q) : miss_cnt_q;
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed steps, a latency-programmable
// backing memory model and a scoreboard of expected instruction words.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] fetch_addr = '0;
    logic        fetch_req = 1'b0;
    logic        inval = 1'b0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        err;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int          total = 0;
    int          bad = 0;
    int          mem_lat = 2;
    logic [15:0] exp_q [$];
    logic [15:0] req_log [$];

    icache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_addr  (fetch_addr),
        .fetch_req   (fetch_req),
        .inval       (inval),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .err         (err),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Backing memory: mem_valid arrives mem_lat cycles after mem_req (mem_lat >= 2).
    // Not reset, so a read in flight across a DUT reset still returns.
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [15:0] mem_pend = '0;
    always @(posedge clk) begin
        mem_valid <= 1'b0;
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                mem_valid <= 1'b1;
                mem_rdata <= mem_model(mem_pend);
                mem_busy  <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
        if (mem_req) begin
            mem_busy <= 1'b1;
            mem_pend <= mem_addr;
            mem_cnt  <= mem_lat - 1;
            req_log.push_back(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one fetch, wait (bounded) for the hit, compare against the scoreboard.
    // exp_lat < 0 skips the latency check; exp_lat > 0 also expects a stalled first cycle.
    task automatic do_fetch(input logic [15:0] a, input int exp_lat, input string tag);
        int          lat;
        logic [15:0] e;
        exp_q.push_back(mem_model(a));
        fetch_addr = a;
        fetch_req  = 1'b1;
        lat        = 0;
        #1;
        if (exp_lat > 0) chk({tag, "_miss_stall"}, {31'd0, stall}, 32'd1);
        while (!instr_valid && lat < 300) begin
            @(negedge clk);
            #1;
            lat++;
        end
        e = exp_q.pop_front();
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, {16'd0, instr}, {16'd0, e});
        chk({tag, "_hit_stall"}, {31'd0, stall}, 32'd0);
        if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
        @(negedge clk);
        fetch_req = 1'b0;
    endtask

    logic [15:0] redir_tab [8];

    initial begin
        int base;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mreq", {31'd0, mem_req}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'h0800);
        @(negedge clk);

        // Cold miss of line 0 with a 2-cycle memory, then hits on the rest of the line
        base = req_log.size();
        do_fetch(16'h0000, 13, "cold0");
        chk("cold0_nreq", req_log.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            chk("cold0_maddr", {16'd0, req_log[base+k]}, 32'(2 * k));
        end
        do_fetch(16'h0002, 0, "hit2");
        do_fetch(16'h0004, 0, "hit4");
        do_fetch(16'h0006, 0, "hit6");
`ifdef ICACHE_STATS_EN
        chk("stat_hits", {16'd0, hit_cnt}, 32'd4);
        chk("stat_miss", {16'd0, miss_cnt}, 32'd1);
`endif

        // Misaligned fetch: error, no fill
        base = req_log.size();
        fetch_addr = 16'h0001;
        fetch_req  = 1'b1;
        #1;
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        repeat (4) @(negedge clk);
        fetch_req = 1'b0;
        chk("mis_noreq", req_log.size() - base, 0);
        @(negedge clk);

        // Conflict on index 0 between tags 0x00 and 0x01
        do_fetch(16'h0100, 13, "conf100");
        do_fetch(16'h0000, 13, "conf000");
        do_fetch(16'h0100, 13, "conf100b");

        // Redirect mid-fill: 0x0040 fill completes, then 0x0080 fills
        base = req_log.size();
        fetch_addr = 16'h0040;
        fetch_req  = 1'b1;
        repeat (3) @(negedge clk);
        do_fetch(16'h0080, -1, "redir80");
        redir_tab = '{16'h0040, 16'h0042, 16'h0044, 16'h0046,
                      16'h0080, 16'h0082, 16'h0084, 16'h0086};
        chk("redir_nreq", req_log.size() - base, 8);
        for (int k = 0; k < 8; k++) begin
            chk("redir_maddr", {16'd0, req_log[base+k]}, {16'd0, redir_tab[k]});
        end
        do_fetch(16'h0040, 0, "redir40");

        // Invalidate in IDLE: same-cycle lookup still hits, next fetch misses
        do_fetch(16'h0000, -1, "inv_fill");
        inval = 1'b1;
        do_fetch(16'h0000, 0, "inv_same");
        inval = 1'b0;
        do_fetch(16'h0000, 13, "inv_after");

        // Invalidate mid-fill: the filled line ends invalid
        base = req_log.size();
        fetch_addr = 16'h0200;
        fetch_req  = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        for (int k = 0; k < 40 && stall; k++) @(negedge clk);
        chk("infill_done", {31'd0, stall}, 32'd0);
        chk("infill_nreq", req_log.size() - base, 4);
        do_fetch(16'h0200, 13, "infill_re");

        // Reset during WAIT; the late mem_valid must be ignored
        mem_lat = 4;
        base = req_log.size();
        fetch_addr = 16'h0300;
        fetch_req  = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("rstw_stall", {31'd0, stall}, 32'd0);
        chk("rstw_mreq", {31'd0, mem_req}, 32'd0);
        chk("rstw_nreq", req_log.size() - base, 1);
        do_fetch(16'h0300, 21, "rstw_re");

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
